// File: rtl/axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_writer
// Purpose  : Write-only AXI4 master splitting commands into INCR bursts that
//            respect MAX_BURST and 4 KB boundaries; one burst in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int                  SIZE       = $clog2(STRB_WIDTH);
  localparam int                  PAGE_BITS  = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
  localparam logic [16:0]         PAGE_BYTES = 17'(2 ** PAGE_BITS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [16:0]           rem_q, rem_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [1:0]            acc_q, acc_d;
  logic                  done_valid_q, done_valid_d;
  logic [1:0]            done_resp_q, done_resp_d;

  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [16:0]           w_cmd_beats;
  logic [1:0]            w_resp_max;
  logic                  w_beat_hs;

  // Burst length limited by remaining beats, MAX_BURST and room left in the
  // current 4 KB page (the whole address space when it is smaller than 4 KB).
  function automatic logic [7:0] calc_awlen(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [16:0] rem);
    logic [31:0] addr_ext;
    logic [16:0] offset;
    logic [16:0] room;
    logic [16:0] beats;
    addr_ext = 32'(addr);
    offset   = 17'(addr_ext & (32'(PAGE_BYTES) - 32'd1));
    room     = (PAGE_BYTES - offset) >> SIZE;
    beats    = rem;
    if (beats > 17'(MAX_BURST)) beats = 17'(MAX_BURST);
    if (beats > room) beats = room;
    return 8'(beats - 17'd1);
  endfunction

  assign w_cmd_addr  = cmd_addr & ALIGN_MASK;
  assign w_cmd_beats = 17'(cmd_len) + 17'd1;
  assign w_resp_max  = (m_axi_bresp > acc_q) ? m_axi_bresp : acc_q;
  assign w_beat_hs   = (state_q == S_W) && wr_valid && m_axi_wready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    beat_cnt_d   = beat_cnt_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    acc_d        = acc_q;
    done_valid_d = 1'b0;
    done_resp_d  = done_resp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d   = w_cmd_addr;
          rem_d    = w_cmd_beats;
          awaddr_d = w_cmd_addr;
          awlen_d  = calc_awlen(w_cmd_addr, w_cmd_beats);
          acc_d    = 2'b00;
          state_d  = S_AW;
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          beat_cnt_d = awlen_q;
          state_d    = S_W;
        end
      end
      S_W: begin
        if (w_beat_hs) begin
          beat_cnt_d = beat_cnt_q - 8'd1;
          addr_d     = addr_q + BEAT_BYTES;
          rem_d      = rem_q - 17'd1;
          if (beat_cnt_q == 8'd0) state_d = S_B;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          acc_d = w_resp_max;
          if (rem_q == 17'd0) begin
            state_d      = S_IDLE;
            done_valid_d = 1'b1;
            done_resp_d  = w_resp_max;
          end else begin
            awaddr_d = addr_q;
            awlen_d  = calc_awlen(addr_q, rem_q);
            state_d  = S_AW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      beat_cnt_q   <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      acc_q        <= 2'b00;
      done_valid_q <= 1'b0;
      done_resp_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      beat_cnt_q   <= beat_cnt_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      acc_q        <= acc_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE) && !rst;
  assign wr_ready      = (state_q == S_W) && m_axi_wready;
  assign done_valid    = done_valid_q;
  assign done_resp     = done_resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state_q == S_AW);
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign m_axi_wlast   = (state_q == S_W) && (beat_cnt_q == 8'd0);
  assign m_axi_wvalid  = (state_q == S_W) && wr_valid;
  assign m_axi_bready  = (state_q == S_B);

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_writer
// Purpose  : Scoreboard bench for axi_burst_writer with a random-stall slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_writer;

  localparam int MB = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr, cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  axi_burst_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } beat_t;

  aw_t        aw_q[$];
  w_t         w_q[$];
  logic [1:0] done_q[$];
  logic [1:0] bresp_q[$];
  beat_t      src_q[$];
  int         touched[$];
  logic [31:0] mem     [0:16383];
  logic [31:0] exp_mem [0:16383];

  int checks = 0, errors = 0;
  int done_count = 0, issued = 0, src_pops = 0;
  int aw_stall = 0, w_stall = 0, b_stall = 0, src_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plan bursts from the splitting rules, queue expectations, then drive the command.
  task automatic issue_cmd(input logic [15:0] addr, input logic [15:0] len,
                           input logic [31:0] base, input bit rnd, input int resp_mode);
    int rem, a, beats, room, k, idx, cyc;
    logic [1:0] worst, r;
    beat_t b;
    a = int'(addr) & 32'hFFFC; rem = int'(len) + 1; k = 0; idx = 0; worst = 2'b00;
    while (rem > 0) begin
      room  = (4096 - (a % 4096)) / 4;
      beats = rem;
      if (beats > MB) beats = MB;
      if (beats > room) beats = room;
      aw_q.push_back('{addr: 16'(a), len: 8'(beats - 1)});
      if (resp_mode == 0)      r = 2'b00;
      else if (resp_mode == 1) r = 2'($urandom_range(0, 3));
      else                     r = (k == 0) ? 2'b00 : 2'b10;
      bresp_q.push_back(r);
      if (r > worst) worst = r;
      for (int i = 0; i < beats; i++) begin
        b.data = rnd ? $urandom : base + 32'(idx);
        b.strb = rnd ? 4'($urandom) : 4'hF;
        src_q.push_back(b);
        w_q.push_back('{data: b.data, strb: b.strb, last: (i == beats - 1)});
        for (int j = 0; j < 4; j++)
          if (b.strb[j]) exp_mem[a / 4][8*j +: 8] = b.data[8*j +: 8];
        touched.push_back(a / 4);
        a = (a + 4) % 65536;
        idx++;
      end
      rem -= beats;
      k++;
    end
    done_q.push_back(worst);
    issued++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    cyc = 0;
    while (1) begin
      #3;
      if (cmd_ready) break;
      if (cyc > 5000) begin
        checks++; errors++;
        $display("FAIL cmd_accept_timeout: got no cmd_ready expected handshake");
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain();
    int cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (done_count < issued && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_done_count", done_count, issued);
  endtask

  // Stream source
  initial begin
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        src_q.delete();
        wr_valid = 1'b0;
      end else if (src_q.size() > 0 && $urandom_range(0, 99) >= src_stall) begin
        wr_valid = 1'b1; wr_data = src_q[0].data; wr_strb = src_q[0].strb;
      end else begin
        wr_valid = 1'b0; wr_data = $urandom; wr_strb = 4'($urandom);
      end
      #3;
      if (!rst && wr_valid && wr_ready) begin
        void'(src_q.pop_front());
        src_pops++;
      end
    end
  end

  // AXI slave with memory
  logic [15:0] s_addr;
  int          pend;
  bit          b_hs;
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    s_addr = '0; pend = 0; b_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; pend = 0; b_hs = 1'b0;
        bresp_q.delete();
      end else begin
        if (b_hs) begin bvalid = 1'b0; b_hs = 1'b0; end
        awready = ($urandom_range(0, 99) >= aw_stall);
        wready  = ($urandom_range(0, 99) >= w_stall);
        if (!bvalid) begin
          bresp = 2'($urandom);
          if (pend > 0 && $urandom_range(0, 99) >= b_stall) begin
            bvalid = 1'b1;
            bresp  = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
          end
        end
      end
      #3;
      if (!rst) begin
        if (awvalid && awready) s_addr = awaddr;
        if (wvalid && wready) begin
          for (int j = 0; j < 4; j++)
            if (wstrb[j]) mem[s_addr[15:2]][8*j +: 8] = wdata[8*j +: 8];
          s_addr = s_addr + 16'd4;
          if (wlast) pend++;
        end
        if (bvalid && bready) begin
          if (bresp_q.size() > 0) void'(bresp_q.pop_front());
          pend--;
          b_hs = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit p_aw_wait, p_cmd_hs, p_b_hs, p_aw_hs, p_done;
    logic [15:0] p_awaddr;
    logic [7:0]  p_awlen;
    aw_t ea;
    w_t  ew;
    p_aw_wait = 0; p_cmd_hs = 0; p_b_hs = 0; p_aw_hs = 0; p_done = 0;
    p_awaddr = '0; p_awlen = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        aw_q.delete(); w_q.delete(); done_q.delete();
        p_aw_wait = 0; p_cmd_hs = 0; p_b_hs = 0; p_aw_hs = 0; p_done = 0;
        continue;
      end
      if (p_aw_wait) begin
        chk("aw_hold_valid", awvalid, 1'b1);
        chk("aw_hold_addr", awaddr, p_awaddr);
        chk("aw_hold_len", awlen, p_awlen);
      end
      if (p_cmd_hs) chk("cmd_to_awvalid", awvalid, 1'b1);
      if (p_b_hs)   chk("b_to_next_or_done", done_valid ^ awvalid, 1'b1);
      if (p_aw_hs)  chk("aw_to_w_ready", wr_ready, wready);
      if (done_valid) begin
        chk("done_after_b", p_b_hs, 1'b1);
        chk("done_one_cycle", p_done, 1'b0);
        chk("done_cmd_ready", cmd_ready, 1'b1);
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done_resp %h expected no done", done_resp);
        end else begin
          chk("done_resp", done_resp, done_q.pop_front());
        end
        done_count++;
      end
      if (awvalid && awready) begin
        chk("awsize", awsize, 3'd2);
        chk("awburst", awburst, 2'b01);
        if (aw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got addr %h len %h expected none", awaddr, awlen);
        end else begin
          ea = aw_q.pop_front();
          chk("awaddr", awaddr, ea.addr);
          chk("awlen", awlen, ea.len);
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got data %h expected none", wdata);
        end else begin
          ew = w_q.pop_front();
          chk("wdata", wdata, ew.data);
          chk("wstrb", wstrb, ew.strb);
          chk("wlast", wlast, ew.last);
        end
      end
      p_aw_wait = awvalid && !awready;
      p_awaddr  = awaddr;
      p_awlen   = awlen;
      p_cmd_hs  = cmd_valid && cmd_ready;
      p_b_hs    = bvalid && bready;
      p_aw_hs   = awvalid && awready;
      p_done    = done_valid;
    end
  end

  // Main sequence
  initial begin
    int cyc, base;
    logic [15:0] ra;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    for (int i = 0; i < 16384; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    repeat (3) @(negedge clk);
    #3;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_done_valid", done_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("rst_awaddr", awaddr, 16'h0000);
    chk("rst_awlen", awlen, 8'h00);
    chk("rst_done_resp", done_resp, 2'b00);

    issue_cmd(16'h0040, 16'd0,  32'hA5A5A5A5, 1'b0, 0); drain();
    issue_cmd(16'h0000, 16'd39, 32'h00000000, 1'b0, 0); drain();
    issue_cmd(16'h0FF8, 16'd3,  32'h00001000, 1'b0, 0); drain();
    issue_cmd(16'h0100, 16'd31, 32'h00002000, 1'b0, 2); drain();

    for (int n = 0; n < 30; n++) begin
      aw_stall  = $urandom_range(0, 60);
      w_stall   = $urandom_range(0, 60);
      b_stall   = $urandom_range(0, 60);
      src_stall = $urandom_range(0, 60);
      if (n % 4 == 0) ra = 16'(4096 * $urandom_range(1, 5) - 4 * $urandom_range(1, 20));
      else            ra = 16'($urandom_range(0, 16'h5FFF));
      issue_cmd(ra, 16'($urandom_range(0, 63)), 32'h0, 1'b1, 1);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    aw_stall = 0; w_stall = 0; b_stall = 0; src_stall = 0;
    issue_cmd(16'h8000, 16'd15, 32'h00003000, 1'b0, 0);
    base = src_pops;
    cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (src_pops < base + 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reset_test_beats_seen", src_pops, base + 2);
    rst = 1'b1;
    issued--;
    @(negedge clk);
    #3;
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_wr_ready", wr_ready, 1'b0);
    chk("mid_rst_bready", bready, 1'b0);
    chk("mid_rst_done_valid", done_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    issue_cmd(16'h8000, 16'd15, 32'h00004000, 1'b0, 0); drain();

    foreach (touched[i])
      chk($sformatf("mem_%04h", touched[i] * 4), mem[touched[i]], exp_mem[touched[i]]);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
